// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/issue controller for the program-counter register.
// Fetches over req/ack, issues to decode over valid/ready, then loads the next PC after execute.
module pc_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    input  logic            exec_done,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc,
    output logic            misalign_trap,
    output logic [31:0]     instret
);
    typedef enum logic [2:0] {BOOT, FETCH, WAIT_ACK, ISSUE, EXEC} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_next_q, pc_next_d, instr_pc_q, instr_pc_d;
    logic [31:0]     instr_out_q, instr_out_d, instret_q, instret_d;
    logic            pc_load_q, pc_load_d, misalign_trap_q, misalign_trap_d;
    logic [XLEN-1:0] target, new_pc;
    logic            fetch_hit, misaligned;

    assign imem_req    = (state_q == FETCH && !stall) || state_q == WAIT_ACK;
    assign imem_addr   = pc_q;
    assign instr_valid = state_q == ISSUE;
    assign fetch_hit   = imem_req && imem_ack;
    assign target      = redirect_valid ? redirect_target : pc_q + XLEN'(4);
    assign misaligned  = redirect_valid && redirect_target[1:0] != 2'b00;
    assign new_pc      = misaligned ? TRAP_VEC : target;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pc_next_d       = pc_next_q;
        instr_out_d     = instr_out_q;
        instr_pc_d      = instr_pc_q;
        instret_d       = instret_q;
        pc_load_d       = 1'b0;
        misalign_trap_d = 1'b0;
        case (state_q)
            BOOT: begin
                pc_d      = RESET_PC;
                pc_next_d = RESET_PC;
                pc_load_d = 1'b1;
                state_d   = FETCH;
            end
            FETCH, WAIT_ACK: begin
                if (fetch_hit) begin
                    instr_out_d = imem_rdata;
                    instr_pc_d  = pc_q;
                    state_d     = ISSUE;
                end else if (imem_req) begin
                    state_d = WAIT_ACK;
                end
            end
            ISSUE: state_d = instr_ready ? EXEC : ISSUE;
            EXEC: begin
                // pc_load_q high while still in EXEC marks the retire cycle
                if (pc_load_q) begin
                    state_d = FETCH;
                end else if (exec_done) begin
                    pc_d            = new_pc;
                    pc_next_d       = new_pc;
                    pc_load_d       = 1'b1;
                    misalign_trap_d = misaligned;
                    instret_d       = instret_q + 32'd1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= BOOT;
            pc_q            <= RESET_PC;
            pc_next_q       <= RESET_PC;
            instr_out_q     <= '0;
            instr_pc_q      <= '0;
            instret_q       <= '0;
            pc_load_q       <= 1'b0;
            misalign_trap_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_next_q       <= pc_next_d;
            instr_out_q     <= instr_out_d;
            instr_pc_q      <= instr_pc_d;
            instret_q       <= instret_d;
            pc_load_q       <= pc_load_d;
            misalign_trap_q <= misalign_trap_d;
        end
    end

    assign pc            = pc_q;
    assign pc_next       = pc_next_q;
    assign instr_out     = instr_out_q;
    assign instr_pc      = instr_pc_q;
    assign instret       = instret_q;
    assign pc_load       = pc_load_q;
    assign misalign_trap = misalign_trap_q;
endmodule
